stream_cipher_engine: RTL and testbench
=======================================

// Module: stream_cipher_engine
// PURPOSE
//  Iterative, multi-round keyed cipher core: the parametrised successor to the 8-bit combinational encrypter/decrypter pair.
//  - One engine performs both encryption and decryption, selected per transaction.
//  - Datapath width and round count are parametrised.
//  - Valid/ready handshakes on input and output; backpressure is supported.
//  - Sits between a message source and sink in the secure-datapath chain, one word per transaction.
// PARAMETERS
//  WIDTH   8  data and key width in bits (>=2)
//  ROUNDS  4  rounds per transaction (1..255)
//  ROT     1  per-round rotate amount (1..WIDTH-1)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      input word/key/mode valid
//  in_ready   out  1      engine can accept a transaction
//  in_data    in   WIDTH  plaintext (mode=0) or ciphertext (mode=1)
//  in_key     in   WIDTH  key, latched at acceptance
//  in_mode    in   1      0 = encrypt, 1 = decrypt, latched at acceptance
//  out_valid  out  1      result valid; held until taken
//  out_ready  in   1      sink accepts result
//  out_data   out  WIDTH  result word
//  busy       out  1      high in RUN state
// BEHAVIOUR
//  Reset (async, reset=1):
//   - State goes to IDLE; data register, key register, mode and round counter are cleared to 0.
//   - Outputs: out_valid=0, out_data=0, busy=0, in_ready=0 while reset is high, then 1 in IDLE.
//   - A transaction in flight is discarded and no output is produced for it.
//  Round key for round r: k_r = rotl(key, r mod WIDTH) ^ r[WIDTH-1:0].
//  Encrypt round: x <= rotl(x ^ k_r, ROT) + k_r (mod 2^WIDTH); rounds are applied r = 0 .. ROUNDS-1.
//  Decrypt round: x <= rotr(x - k_r, ROT) ^ k_r (mod 2^WIDTH); rounds are applied r = ROUNDS-1 .. 0.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. On in_valid at an edge: latch data/key/mode, set round counter (0 for encrypt, ROUNDS-1 for decrypt), go to RUN.
//   - RUN: in_ready=0, busy=1. Each edge applies one round and steps the counter up (encrypt) or down (decrypt). The last round goes to DONE.
//   - DONE: out_valid=1 and out_data is stable.
//     - out_ready=1: the result is consumed at the edge.
//     - in_ready = out_ready, so a new transaction is accepted at the same edge (back-to-back) and the state goes to RUN; otherwise it goes to IDLE.
//     - out_ready=0: hold all outputs.
//  Latency: out_valid rises exactly ROUNDS cycles after the acceptance edge.
//   - Throughput is one word per ROUNDS+1 cycles with out_ready tied high.
//  Inputs are ignored whenever in_ready=0; in_data/in_key changes during RUN have no effect.
//  Counter wrap: the counter is ceil(log2(ROUNDS+1)) bits and never wraps; the terminal round is detected by compare, not by overflow.
//  Arithmetic is unsigned and truncated to WIDTH bits; the round key index r is zero-extended/truncated to WIDTH.
//  Reset asserted in any state overrides the handshake in that cycle.
// STRUCTURE
//  - Shared header cipher_defs.vh holds:
//    - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//    - MODE_ENC/MODE_DEC constants
//    - rotl/rotr functions, reused by the bench reference model
//  - Sub-module cipher_round is combinational: one round in either direction.
//    - Inputs: x, key, r, mode. Output: x_next. Parameterised by WIDTH and ROT.
//  - Top level holds the FSM, round counter, key/mode/data registers, and the output register.
// TESTING
//  1. WIDTH=8, ROUNDS=1, encrypt data=0x55 key=0x43 -> out_data=0x6F, out_valid 1 cycle after accept.
//  2. Same configuration, decrypt data=0x6F key=0x43 -> out_data=0x55.
//  3. WIDTH=8, ROUNDS=1, encrypt 0x80 with key 0x00 -> 0x01 (exercises the rotate carry-around).
//  4. Defaults: encrypt 0x55, 0x0F, 0xF0 with key 0x43, then decrypt each result with out_ready high -> originals returned.
//     - Accepts are back-to-back and spaced exactly 5 cycles apart.
//  5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, new in_valid ignored.
//     - out_ready=1 -> one output only.
//  6. Assert reset 2 cycles into RUN -> out_valid=0 and busy=0 immediately, no output appears.
//     - After release, the next transaction is correct.

Source files
------------

// File: rtl/stream_cipher_engine_pkg.sv
// Shared definitions for the stream cipher engine: FSM state encodings, mode
// constants and width-generic rotate helpers (usable for widths up to MAX_W).
package stream_cipher_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        logic [MAX_W-1:0] m;
        if (w >= MAX_W) m = '1;
        else            m = (MAX_W'(1) << w) - MAX_W'(1);
        return m;
    endfunction

    // The value is duplicated side by side so a plain shift yields the rotation.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                              input int unsigned sh,
                                              input int unsigned w);
        logic [2*MAX_W-1:0] d;
        logic [MAX_W-1:0]   v;
        v = x & width_mask(w);
        d = {{MAX_W{1'b0}}, v} | ({{MAX_W{1'b0}}, v} << w);
        d = d << sh;
        return MAX_W'(d >> w) & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x,
                                              input int unsigned sh,
                                              input int unsigned w);
        logic [2*MAX_W-1:0] d;
        logic [MAX_W-1:0]   v;
        v = x & width_mask(w);
        d = {{MAX_W{1'b0}}, v} | ({{MAX_W{1'b0}}, v} << w);
        d = d >> sh;
        return MAX_W'(d) & width_mask(w);
    endfunction

endpackage

// File: rtl/stream_cipher_engine_round.sv
// One combinational cipher round in either direction, including the round-key
// derivation k_r = rotl(key, r mod WIDTH) ^ r.
module cipher_round
    import stream_cipher_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROT   = 1,
    parameter int RW    = 3
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] key,
    input  logic [RW-1:0]    r,
    input  logic             mode,
    output logic [WIDTH-1:0] x_next
);

    localparam int unsigned W_U   = WIDTH;
    localparam int unsigned ROT_U = ROT;

    logic [31:0]      amt;
    logic [WIDTH-1:0] r_ext;
    logic [WIDTH-1:0] rk;
    logic [WIDTH-1:0] mixed;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rot_enc;
    logic [WIDTH-1:0] rot_dec;

    // Intermediates keep the subtract at WIDTH bits so the borrow is dropped.
    always_comb begin
        amt     = 32'(r) % 32'(WIDTH);
        r_ext   = WIDTH'(r);
        rk      = WIDTH'(rotl(MAX_W'(key), amt, W_U)) ^ r_ext;
        mixed   = x ^ rk;
        diff    = x - rk;
        rot_enc = WIDTH'(rotl(MAX_W'(mixed), ROT_U, W_U));
        rot_dec = WIDTH'(rotr(MAX_W'(diff), ROT_U, W_U));
        if (mode == MODE_ENC) x_next = rot_enc + rk;
        else                  x_next = rot_dec ^ rk;
    end

endmodule

// File: rtl/stream_cipher_engine.sv
// Iterative keyed cipher engine: accepts one word, runs ROUNDS rounds (one per
// cycle) forward or backward, then holds the result until the sink takes it.
module stream_cipher_engine
    import stream_cipher_engine_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROUNDS = 4,
    parameter int ROT    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_key,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // Handshake: a word moves on a rising edge where valid and ready are both
    // high; out_valid/out_data never change while out_valid=1 and out_ready=0.

    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ROUNDS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [WIDTH-1:0] round_x;
    logic             last_round;
    logic             accept;
    logic             ready_c;

    cipher_round #(
        .WIDTH (WIDTH),
        .ROT   (ROT),
        .RW    (CW)
    ) u_round (
        .x      (data_q),
        .key    (key_q),
        .r      (cnt_q),
        .mode   (mode_q),
        .x_next (round_x)
    );

    // Terminal round found by compare, so the counter never steps past its range.
    assign last_round = (mode_q == MODE_ENC) ? (cnt_q == CNT_LAST) : (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        key_d     = key_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        ready_c   = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                accept  = in_valid;
            end
            ST_RUN: begin
                busy   = 1'b1;
                data_d = round_x;
                if (last_round) begin
                    state_d = ST_DONE;
                    out_d   = round_x;
                end else if (mode_q == MODE_ENC) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                ready_c   = out_ready;
                if (out_ready) begin
                    if (in_valid) accept  = 1'b1;
                    else          state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_RUN;
            data_d  = in_data;
            key_d   = in_key;
            mode_d  = in_mode;
            cnt_d   = (in_mode == MODE_DEC) ? CNT_LAST : '0;
        end
    end

    assign in_ready = ready_c & ~reset;
    assign out_data = out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_stream_cipher_engine.sv
// Directed bench for stream_cipher_engine: a ROUNDS=1 instance for the
// single-round vectors and a default instance for streaming, stall and reset.
module tb_stream_cipher_engine;

    logic       clk = 1'b0;
    logic       reset;

    logic       in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic [7:0] in_data, in_key, out_data;

    logic       s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_busy;
    logic [7:0] s_in_data, s_in_key, s_out_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];

    stream_cipher_engine #(.WIDTH(8), .ROUNDS(4), .ROT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    stream_cipher_engine #(.WIDTH(8), .ROUNDS(1), .ROT(1)) dut_r1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_key    (s_in_key),
        .in_mode   (s_in_mode),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .busy      (s_busy)
    );

    // ---------------- clock / cycle counter / output monitor ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] k, input logic m,
                        input bit hold, output int acc);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_mode  = m;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        tick();
        acc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 100) begin
            tick();
            t++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL output_timeout: got %0d outputs, required %0d", got_q.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_key      = '0;
        in_mode     = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_in_key    = '0;
        s_in_mode   = 1'b0;
        s_out_ready = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0 || s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b, required 0/0", in_ready, s_in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        checks++;
        if (out_data !== 8'h00 || s_out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_data: got %h/%h, required 00/00", out_data, s_out_data);
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready: got %b/%b, required 1/1", in_ready, s_in_ready);
        end
        tick();
    endtask

    task automatic test_single_round();
        logic [7:0] sd[3];
        logic [7:0] sk[3];
        logic       sm[3];
        logic [7:0] se[3];
        sd = '{8'h55, 8'h6F, 8'h80};
        sk = '{8'h43, 8'h43, 8'h00};
        sm = '{1'b0, 1'b1, 1'b0};
        se = '{8'h6F, 8'h55, 8'h01};
        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = sd[i];
            s_in_key   = sk[i];
            s_in_mode  = sm[i];
            checks++;
            if (s_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL r1_ready[%0d]: got %b, required 1", i, s_in_ready);
            end
            tick();
            s_in_valid = 1'b0;
            checks++;
            if (s_out_valid !== 1'b0 || s_busy !== 1'b1) begin
                errors++;
                $display("FAIL r1_run[%0d]: out_valid=%b busy=%b, required 0 1", i, s_out_valid, s_busy);
            end
            tick();
            checks++;
            if (s_out_valid !== 1'b1 || s_out_data !== se[i]) begin
                errors++;
                $display("FAIL r1_result[%0d]: out_valid=%b data=%h, required 1 %h",
                         i, s_out_valid, s_out_data, se[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[6];
        logic       m[6];
        logic [7:0] e[6];
        int         acc[6];
        logic [7:0] got, exp;
        int         gc;
        d = '{8'h55, 8'h0F, 8'hF0, 8'h62, 8'h05, 8'h04};
        m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e = '{8'h62, 8'h05, 8'h04, 8'h55, 8'h0F, 8'hF0};
        out_ready = 1'b1;
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e[i]);
            send(d[i], 8'h43, m[i], 1'b1, acc[i]);
        end
        in_valid = 1'b0;
        wait_got(6);
        for (int i = 0; i < 6; i++) begin
            if (got_q.size() > 0) begin
                got = got_q.pop_front();
                gc  = got_cyc_q.pop_front();
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h, required %h", i, got, exp);
                end
                checks++;
                if (gc - acc[i] != 4) begin
                    errors++;
                    $display("FAIL b2b_latency[%0d]: got %0d cycles, required 4", i, gc - acc[i]);
                end
            end
        end
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 5) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 5", i, acc[i] - acc[i-1]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int acc;
        int n;
        out_ready = 1'b0;
        got_q.delete();
        got_cyc_q.delete();
        send(8'h55, 8'h43, 1'b0, 1'b0, acc);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || cyc - acc != 4) begin
            errors++;
            $display("FAIL bp_latency: out_valid=%b after %0d cycles, required 1 after 4", out_valid, cyc - acc);
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            in_key   = 8'h11;
            in_mode  = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h62 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b data=%h in_ready=%b, required 1 62 0",
                         k, out_valid, out_data, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs, required 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 8'h62) begin
                errors++;
                $display("FAIL bp_data: got %h, required 62", got_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int acc;
        logic [7:0] got;
        int gc;
        out_ready = 1'b1;
        got_q.delete();
        got_cyc_q.delete();
        send(8'h0F, 8'h43, 1'b0, 1'b0, acc);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b, required 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b busy=%b in_ready=%b, required 0 0 0",
                     out_valid, busy, in_ready);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_data: got %h, required 00", out_data);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL mid_no_output: got %0d outputs, required 0", got_q.size());
        end
        got_q.delete();
        got_cyc_q.delete();
        send(8'hF0, 8'h43, 1'b0, 1'b0, acc);
        wait_got(1);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            gc  = got_cyc_q.pop_front();
            checks++;
            if (got !== 8'h04 || gc - acc != 4) begin
                errors++;
                $display("FAIL post_reset_txn: data=%h latency=%0d, required 04 4", got, gc - acc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
